// File: rtl/aes_pkg.sv
// Shared AES MixColumns definitions: GF(2^8) constants, coefficient rows,
// FSM states, state typedefs and row-major column access helpers.
package aes_pkg;

  typedef logic [7:0]   byte_t;
  typedef logic [31:0]  col_t;    // {a0, a1, a2, a3}, a0 in the top byte
  typedef logic [127:0] state_t;  // s(0,0) in bits [127:120], row-major
  typedef byte_t [0:3]  coef_t;   // first row of a circulant matrix

  // Low byte of the AES field modulus x^8+x^4+x^3+x+1.
  localparam byte_t GF_POLY_LOW = 8'h1B;

  // First rows of the forward and inverse MixColumns circulant matrices.
  localparam coef_t FWD_COEF = {8'h02, 8'h03, 8'h01, 8'h01};
  localparam coef_t INV_COEF = {8'h0E, 8'h0B, 8'h0D, 8'h09};

  typedef enum logic [1:0] {IDLE, BUSY, DONE} fsm_e;

  function automatic byte_t xtime(byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? GF_POLY_LOW : 8'h00);
  endfunction

  // Multiply by a constant below 0x10 using an xtime chain; with constant
  // coefficients this reduces to XOR networks.
  function automatic byte_t gf_mul_small(byte_t b, logic [3:0] k);
    byte_t acc;
    byte_t p;
    acc = '0;
    p   = b;
    for (int i = 0; i < 4; i++) begin
      if (k[i]) acc ^= p;
      p = xtime(p);
    end
    return acc;
  endfunction

  // Gather column c from the row-major state.
  function automatic col_t get_col(state_t s, logic [1:0] c);
    col_t col;
    for (int r = 0; r < 4; r++)
      col[31-8*r -: 8] = s[127-32*r-8*int'(c) -: 8];
    return col;
  endfunction

  // Scatter a column back into the row-major state.
  function automatic state_t set_col(state_t s, logic [1:0] c, col_t col);
    state_t res;
    res = s;
    for (int r = 0; r < 4; r++)
      res[127-32*r-8*int'(c) -: 8] = col[31-8*r -: 8];
    return res;
  endfunction

endpackage

// File: rtl/mix_column_gf.sv
// Combinational MixColumns of one column, forward or inverse.
module mix_column_gf
  import aes_pkg::*;
(
  input  logic [31:0] col_in,
  input  logic        inv,
  output logic [31:0] col_out
);

  coef_t coef;

  assign coef = inv ? INV_COEF : FWD_COEF;

  // b_r = XOR_k M[r][k] * a_k, where row r is the first row rotated right by r.
  always_comb begin
    // NOTE: every output of an always_comb gets a value before any
    // conditional or accumulating logic, otherwise a latch is inferred.
    col_out = '0;
    for (int r = 0; r < 4; r++)
      for (int k = 0; k < 4; k++)
        col_out[31-8*r -: 8] ^= gf_mul_small(col_in[31-8*k -: 8],
                                             coef[(k-r+4)%4][3:0]);
  end

endmodule

// File: rtl/mix_columns_seq.sv
// Iterative AES MixColumns engine: transforms COLS_PER_CYCLE columns per
// cycle of a registered 128-bit state, valid/ready on both sides.
module mix_columns_seq
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic         in_inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state
);

  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_param
    $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  localparam int         K    = 4 / COLS_PER_CYCLE;
  localparam logic [1:0] LAST = 2'(K - 1);

  fsm_e       state_q, state_d;
  logic [1:0] col_cnt_q;
  state_t     st_q, st_d;
  logic       inv_q;

  logic [1:0] col_idx [COLS_PER_CYCLE];
  col_t       col_in  [COLS_PER_CYCLE];
  col_t       col_out [COLS_PER_CYCLE];

  for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
    assign col_idx[g] = 2'(int'(col_cnt_q) * COLS_PER_CYCLE + g);
    assign col_in[g]  = get_col(st_q, col_idx[g]);

    mix_column_gf u_gf (
      .col_in  (col_in[g]),
      .inv     (inv_q),
      .col_out (col_out[g])
    );
  end

  // Merge this cycle's transformed columns into the state.
  always_comb begin
    st_d = st_q;
    for (int g = 0; g < COLS_PER_CYCLE; g++)
      st_d = set_col(st_d, col_idx[g], col_out[g]);
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = BUSY;
      end
      BUSY: begin
        if (col_cnt_q == LAST) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM, column counter and state register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q   <= IDLE;
      col_cnt_q <= '0;
      st_q      <= '0;
      inv_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && in_valid) begin
        st_q      <= in_state;
        inv_q     <= in_inv;
        col_cnt_q <= '0;
      end else if (state_q == BUSY) begin
        st_q      <= st_d;
        col_cnt_q <= col_cnt_q + 2'd1;
      end
    end
  end

  assign out_state = st_q;

endmodule

// File: tb/tb_mix_columns_seq.sv
// Scoreboard bench: drives three engines (1, 2, 4 columns/cycle) in lockstep
// and checks each result against an independent GF(2^8) reference model.
module tb_mix_columns_seq;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_inv = 1'b0;
  logic [127:0] in_state = '0;
  logic [2:0]   in_ready_v;
  logic [2:0]   out_valid_v;
  logic [2:0]   out_ready_v = '0;
  logic [127:0] out_state_v [3];

  int checks = 0;
  int errors = 0;

  logic [127:0] sb [$];
  int           rd_idx [3] = '{0, 0, 0};
  bit           stall_mode = 1'b0;
  bit           ready_force = 1'b1;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mix_columns_seq #(.COLS_PER_CYCLE(1 << g)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready_v[g]),
      .in_state  (in_state),
      .in_inv    (in_inv),
      .out_valid (out_valid_v[g]),
      .out_ready (out_ready_v[g]),
      .out_state (out_state_v[g])
    );
  end

  task automatic check(string tag, logic [127:0] got, logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: generic GF(2^8) multiply and explicit matrices.
  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
    end
    return p;
  endfunction

  function automatic logic [127:0] ref_mc(logic [127:0] s, bit inv);
    logic [7:0] mf [4][4];
    logic [7:0] mi [4][4];
    logic [7:0] acc;
    logic [127:0] res;
    mf = '{'{8'h02, 8'h03, 8'h01, 8'h01}, '{8'h01, 8'h02, 8'h03, 8'h01},
           '{8'h01, 8'h01, 8'h02, 8'h03}, '{8'h03, 8'h01, 8'h01, 8'h02}};
    mi = '{'{8'h0e, 8'h0b, 8'h0d, 8'h09}, '{8'h09, 8'h0e, 8'h0b, 8'h0d},
           '{8'h0d, 8'h09, 8'h0e, 8'h0b}, '{8'h0b, 8'h0d, 8'h09, 8'h0e}};
    res = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = '0;
        for (int k = 0; k < 4; k++)
          acc ^= gmul(s[127-32*k-8*c -: 8], inv ? mi[r][k] : mf[r][k]);
        res[127-32*r-8*c -: 8] = acc;
      end
    return res;
  endfunction

  function automatic logic [127:0] mk_state(logic [31:0] c0, logic [31:0] c1,
                                            logic [31:0] c2, logic [31:0] c3);
    logic [31:0]  cols [4];
    logic [127:0] s;
    cols = '{c0, c1, c2, c3};
    s = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        s[127-32*r-8*c -: 8] = cols[c][31-8*r -: 8];
    return s;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Consumer-side ready: forced level or random stalls.
  initial forever begin
    @(posedge clk);
    #1;
    for (int g = 0; g < 3; g++)
      out_ready_v[g] = stall_mode ? 1'($urandom_range(0, 1)) : ready_force;
  end

  // Output monitor: compare each delivered result with the scoreboard.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      for (int g = 0; g < 3; g++)
        if (out_valid_v[g] && out_ready_v[g]) begin
          if (rd_idx[g] < sb.size()) begin
            check($sformatf("dut%0d_data", g), out_state_v[g], sb[rd_idx[g]]);
            rd_idx[g]++;
          end else begin
            check($sformatf("dut%0d_spurious_out", g), 128'(out_valid_v[g]), 128'd0);
          end
        end
      while (sb.size() > 0 && rd_idx[0] > 0 && rd_idx[1] > 0 && rd_idx[2] > 0) begin
        void'(sb.pop_front());
        for (int g = 0; g < 3; g++) rd_idx[g]--;
      end
    end
  end

  // Offer one state; returns at posedge+1 just after the accept edge.
  task automatic send(logic [127:0] s, bit inv, logic [127:0] exp);
    int n = 0;
    while (in_ready_v !== 3'b111 && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 300) check("accept_timeout", 128'(in_ready_v), 128'd7);
    sb.push_back(exp);
    in_valid = 1'b1;
    in_state = s;
    in_inv   = inv;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_state = rand128();
    in_inv   = 1'($urandom_range(0, 1));
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_done", 128'(sb.size() == 0), 128'd1);
    sb.delete();
    rd_idx = '{0, 0, 0};
  endtask

  // Latency, input-isolation and stall checks on one transfer.
  task automatic lat_test(string tag, logic [127:0] s, bit inv, logic [127:0] exp);
    int lat [3] = '{-1, -1, -1};
    ready_force = 1'b0;
    send(s, inv, exp);
    for (int cyc = 1; cyc <= 8; cyc++) begin
      for (int g = 0; g < 3; g++)
        if (out_valid_v[g] && lat[g] < 0) lat[g] = cyc;
      check({tag, "_in_ready_busy"}, 128'(in_ready_v), 128'd0);
      in_state = rand128();
      in_inv   = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    for (int g = 0; g < 3; g++)
      check($sformatf("%s_latency_dut%0d", tag, g), 128'(lat[g]), 128'((4 >> g) + 1));
    for (int i = 0; i < 10; i++) begin
      check({tag, "_stall_valid"}, 128'(out_valid_v), 128'd7);
      check({tag, "_stall_in_ready"}, 128'(in_ready_v), 128'd0);
      for (int g = 0; g < 3; g++)
        check($sformatf("%s_stall_data_dut%0d", tag, g), out_state_v[g], exp);
      @(posedge clk);
      #1;
    end
    ready_force = 1'b1;
    drain();
  endtask

  logic [127:0] vec_a, out_a, vec_d, out_d, x, y;

  initial begin
    vec_a = mk_state(32'hdb135345, 32'hf20a225c, 32'h01010101, 32'hc6c6c6c6);
    out_a = mk_state(32'h8e4da1bc, 32'h9fdc589d, 32'h01010101, 32'hc6c6c6c6);
    vec_d = mk_state(32'hd4d4d4d5, 32'hd4d4d4d5, 32'hd4d4d4d5, 32'hd4d4d4d5);
    out_d = mk_state(32'hd5d5d7d6, 32'hd5d5d7d6, 32'hd5d5d7d6, 32'hd5d5d7d6);

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int g = 0; g < 3; g++) begin
      check($sformatf("reset_out_valid_dut%0d", g), 128'(out_valid_v[g]), 128'd0);
      check($sformatf("reset_in_ready_dut%0d", g), 128'(in_ready_v[g]), 128'd1);
      check($sformatf("reset_out_state_dut%0d", g), out_state_v[g], 128'd0);
    end

    lat_test("fwd_a", vec_a, 1'b0, out_a);
    lat_test("inv_a", out_a, 1'b1, vec_a);
    lat_test("fwd_d", vec_d, 1'b0, out_d);

    // Reset in BUSY cycle 2 discards the transfer.
    ready_force = 1'b0;
    send(vec_a, 1'b0, out_a);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    rd_idx = '{0, 0, 0};
    check("midreset_out_valid", 128'(out_valid_v), 128'd0);
    check("midreset_in_ready", 128'(in_ready_v), 128'd7);
    ready_force = 1'b1;
    send(vec_d, 1'b0, out_d);
    drain();

    // Random back-to-back traffic with random consumer stalls.
    stall_mode = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bit inv;
      x   = rand128();
      inv = 1'($urandom_range(0, 1));
      send(x, inv, ref_mc(x, inv));
    end
    for (int i = 0; i < 5; i++) begin
      x = rand128();
      y = ref_mc(x, 1'b0);
      send(x, 1'b0, y);
      send(y, 1'b1, x);
    end
    drain();
    stall_mode = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
